// File: rtl/apu_frame_counter.sv
// APU frame sequencer: generates the quarter-frame (nLFO1) and half-frame
// (nLFO2) strobes, the frame interrupt, and handles $4017 writes and the
// $4015 status-read interrupt acknowledge.
module apu_frame_counter #(
    parameter int P1       = 3728,
    parameter int P2       = 7456,
    parameter int P3       = 11185,
    parameter int P4       = 14914,
    parameter int P5       = 18640,
    parameter int WR_DELAY = 2
) (
    input  logic       ACLK,
    input  logic       n_RES,
    input  logic       W4017,
    input  logic       R4015,
    input  logic [7:0] DB,
    output logic       nLFO1,
    output logic       nLFO2,
    output logic       INT,
    output logic       n_IRQ
);

    localparam int DW = (WR_DELAY < 2) ? 1 : $clog2(WR_DELAY + 1);

    logic [14:0]   cnt;
    logic          mode;      // 1 = 5-step sequence
    logic          inh;       // interrupt inhibit
    logic [DW-1:0] dly;       // pending-write countdown, 0 = idle

    logic m1, m2, m3, m4, m5;
    logic ev4, ev5;
    logic restart;
    logic q_evt, h_evt;
    logic int_set, int_clr;
    logic wrap;

    // DB[5:0] carry no frame-counter state.
    logic unused_db;
    assign unused_db = ^DB[5:0];

    // Threshold decode, restart detect and event/wrap selection for this cycle.
    always_comb begin
        m1 = (cnt == 15'(P1));
        m2 = (cnt == 15'(P2));
        m3 = (cnt == 15'(P3));
        m4 = (cnt == 15'(P4));
        m5 = (cnt == 15'(P5));
        ev4 = m4 & ~mode;
        ev5 = m5 & mode;
        // A fresh write landing on the expiry cycle reloads the delay instead.
        restart = (dly == DW'(1)) & ~W4017;
        q_evt   = m1 | m2 | m3 | ev4 | ev5 | (restart & mode);
        h_evt   = m2 | ev4 | ev5 | (restart & mode);
        int_set = ev4 & ~inh;
        int_clr = R4015 | (W4017 & DB[6]);
        // P5 wraps in either mode so a late switch to 4-step can never run past it.
        wrap    = ev4 | m5;
    end

    // Sequence counter: forced to zero by a restart or at the end of the sequence.
    always_ff @(posedge ACLK or negedge n_RES) begin
        if (!n_RES)
            cnt <= '0;
        else if (restart || wrap)
            cnt <= '0;
        else
            cnt <= cnt + 15'd1;
    end

    // Mode and inhibit latch straight from the bus on the write strobe.
    always_ff @(posedge ACLK or negedge n_RES) begin
        if (!n_RES) begin
            mode <= 1'b0;
            inh  <= 1'b0;
        end else if (W4017) begin
            mode <= DB[7];
            inh  <= DB[6];
        end
    end

    // Write-to-restart delay; a repeated write reloads it (last write wins).
    always_ff @(posedge ACLK or negedge n_RES) begin
        if (!n_RES)
            dly <= '0;
        else if (W4017)
            dly <= DW'(WR_DELAY);
        else if (dly != '0)
            dly <= dly - DW'(1);
    end

    // Registered one-cycle active-low strobes, one ACLK after the match.
    always_ff @(posedge ACLK or negedge n_RES) begin
        if (!n_RES) begin
            nLFO1 <= 1'b1;
            nLFO2 <= 1'b1;
        end else begin
            nLFO1 <= ~q_evt;
            nLFO2 <= ~h_evt;
        end
    end

    // Frame interrupt flag: a set on the same edge as a clear takes priority.
    always_ff @(posedge ACLK or negedge n_RES) begin
        if (!n_RES)
            INT <= 1'b0;
        else if (int_set)
            INT <= 1'b1;
        else if (int_clr)
            INT <= 1'b0;
    end

    assign n_IRQ = ~INT;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Bench for apu_frame_counter: a timeline model (edges since reset, start of
// the current sequence, scheduled restart) predicts the outputs every cycle;
// directed literal checks pin the model at hand-computed edges.
module tb_apu_frame_counter;

    localparam int WR_DELAY = 2;

    logic       ACLK;
    logic       n_RES;
    logic       W4017;
    logic       R4015;
    logic [7:0] DB;
    logic       nLFO1, nLFO2, INT, n_IRQ;

    int errors = 0;
    int checks = 0;

    apu_frame_counter dut (
        .ACLK  (ACLK),
        .n_RES (n_RES),
        .W4017 (W4017),
        .R4015 (R4015),
        .DB    (DB),
        .nLFO1 (nLFO1),
        .nLFO2 (nLFO2),
        .INT   (INT),
        .n_IRQ (n_IRQ)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Step thresholds and which events each step raises, per mode.
    int pt [5] = '{3728, 7456, 11185, 14914, 18640};
    bit q_tab [2][5] = '{'{1, 1, 1, 1, 0}, '{1, 1, 1, 0, 1}};
    bit h_tab [2][5] = '{'{0, 1, 0, 1, 0}, '{0, 1, 0, 0, 1}};

    // Model state
    int m_e;        // edges since reset release
    int m_base;     // edge at which the sequence last started from zero
    int m_rst_at;   // edge at which a pending write restarts the sequence
    bit m_mode, m_inh, m_int;
    bit exp_q, exp_h;
    int v;
    bit q, h, rs, wrap;

    // Model: advance the timeline at every edge using the inputs seen there.
    always @(posedge ACLK) begin
        if (!n_RES) begin
            m_e = 0; m_base = 0; m_rst_at = -1;
            m_mode = 0; m_inh = 0; m_int = 0;
            exp_q = 0; exp_h = 0;
        end else begin
            m_e = m_e + 1;
            v = m_e - 1 - m_base;
            q = 0; h = 0;
            for (int i = 0; i < 5; i++)
                if (v == pt[i]) begin
                    q = q | q_tab[m_mode][i];
                    h = h | h_tab[m_mode][i];
                end
            wrap = (v == pt[4]) || (v == pt[3] && !m_mode);
            rs = (m_e == m_rst_at) && !W4017;
            if (rs && m_mode) begin q = 1; h = 1; end
            if (v == pt[3] && !m_mode && !m_inh) m_int = 1;
            else if (R4015 || (W4017 && DB[6])) m_int = 0;
            if (W4017) begin
                m_mode = DB[7];
                m_inh = DB[6];
                m_rst_at = m_e + WR_DELAY;
            end
            if (rs || wrap) m_base = m_e;
            exp_q = q;
            exp_h = h;
        end
    end

    // Compare every out-of-reset cycle against the model.
    always @(negedge ACLK) begin
        if (n_RES) begin
            checks++;
            if (nLFO1 !== !exp_q || nLFO2 !== !exp_h || INT !== m_int || n_IRQ !== !m_int) begin
                errors++;
                $display("FAIL model edge %0d: nLFO1,nLFO2,INT,n_IRQ got %b%b%b%b want %b%b%b%b",
                         m_e, nLFO1, nLFO2, INT, n_IRQ, !exp_q, !exp_h, m_int, !m_int);
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b want %b", name, m_e, act, want);
        end
    endtask

    // Park 2 time units after edge n (model already updated).
    task automatic goto_edge(input int n);
        while (m_e < n) begin
            @(posedge ACLK);
            #2;
        end
    endtask

    task automatic strobe_at(input int n, input logic [7:0] d);
        goto_edge(n - 1);
        W4017 = 1'b1;
        DB    = d;
        @(posedge ACLK);
        #2;
        W4017 = 1'b0;
    endtask

    task automatic read_at(input int n);
        goto_edge(n - 1);
        R4015 = 1'b1;
        @(posedge ACLK);
        #2;
        R4015 = 1'b0;
    endtask

    initial begin
        n_RES = 1'b0; W4017 = 1'b0; R4015 = 1'b0; DB = 8'h00;
        #12;
        chk("rst_nLFO1", nLFO1, 1'b1);
        chk("rst_nLFO2", nLFO2, 1'b1);
        chk("rst_INT",   INT,   1'b0);
        chk("rst_n_IRQ", n_IRQ, 1'b1);
        @(posedge ACLK); #1; n_RES = 1'b1;

        // 4-step sequence from reset release
        goto_edge(3728);  chk("q_before_P1", nLFO1, 1'b1);
        goto_edge(3729);  chk("q_P1", nLFO1, 1'b0); chk("h_P1", nLFO2, 1'b1);
        goto_edge(7457);  chk("q_P2", nLFO1, 1'b0); chk("h_P2", nLFO2, 1'b0);
        goto_edge(11186); chk("q_P3", nLFO1, 1'b0); chk("h_P3", nLFO2, 1'b1);
        goto_edge(14914); chk("int_before_P4", INT, 1'b0);
        goto_edge(14915); chk("q_P4", nLFO1, 1'b0); chk("h_P4", nLFO2, 1'b0);
        chk("int_P4", INT, 1'b1); chk("irq_P4", n_IRQ, 1'b0);
        goto_edge(18644); chk("q_P1_seq2", nLFO1, 1'b0);

        // Status read on an idle cycle clears; on a P4 edge the set wins.
        read_at(18650);   chk("int_rd_idle", INT, 1'b0); chk("irq_rd_idle", n_IRQ, 1'b1);
        read_at(29830);   chk("int_rd_on_P4", INT, 1'b1);

        // Inhibit write clears INT on its edge, later P4 leaves it clear.
        strobe_at(29835, 8'h40); chk("int_inh_wr", INT, 1'b0);
        goto_edge(44752); chk("h_P4_inh", nLFO2, 1'b0); chk("int_P4_inh", INT, 1'b0);

        // Back-to-back writes: restart two edges after the second, 4-step, no pulse.
        strobe_at(44760, 8'h80);
        strobe_at(44761, 8'h00);
        goto_edge(44762); chk("q_no_early_restart", nLFO1, 1'b1);
        goto_edge(44763); chk("q_no_restart_pulse", nLFO1, 1'b1); chk("h_no_restart_pulse", nLFO2, 1'b1);
        goto_edge(48492); chk("q_P1_after_restart", nLFO1, 1'b0);

        // P4 with interrupt re-enabled, plus a pending write, then async reset.
        strobe_at(59677, 8'h00);
        goto_edge(59678); chk("h_P4_reen", nLFO2, 1'b0); chk("int_P4_reen", INT, 1'b1);
        #1 n_RES = 1'b0;
        #1;
        chk("async_nLFO2", nLFO2, 1'b1);
        chk("async_nLFO1", nLFO1, 1'b1);
        chk("async_INT",   INT,   1'b0);
        chk("async_n_IRQ", n_IRQ, 1'b1);
        @(posedge ACLK); @(posedge ACLK); #1; n_RES = 1'b1;

        goto_edge(3728);  chk("q_before_P1_rst2", nLFO1, 1'b1);
        goto_edge(3729);  chk("q_P1_rst2", nLFO1, 1'b0);

        // 5-step write: immediate pulse at restart, no event at P4, wrap at P5.
        strobe_at(3735, 8'h80);
        goto_edge(3736);  chk("q_pending5", nLFO1, 1'b1);
        goto_edge(3737);  chk("q_restart5", nLFO1, 1'b0); chk("h_restart5", nLFO2, 1'b0);
        goto_edge(7466);  chk("q5_P1", nLFO1, 1'b0); chk("h5_P1", nLFO2, 1'b1);
        goto_edge(11194); chk("q5_P2", nLFO1, 1'b0); chk("h5_P2", nLFO2, 1'b0);
        goto_edge(14923); chk("q5_P3", nLFO1, 1'b0);
        goto_edge(18652); chk("q5_P4_none", nLFO1, 1'b1); chk("h5_P4_none", nLFO2, 1'b1);
        chk("int5_P4", INT, 1'b0);
        goto_edge(22378); chk("q5_P5", nLFO1, 1'b0); chk("h5_P5", nLFO2, 1'b0);
        goto_edge(26107); chk("q5_P1_seq2", nLFO1, 1'b0); chk("int5_seq2", INT, 1'b0);
        goto_edge(26110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
